// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared scoreboard types and constants
package scoreboard_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        UPDATE    = 2'd1,
        CHECK     = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    typedef enum logic {
        PL_P1 = 1'b0,
        PL_P2 = 1'b1
    } player_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Display sequencer glyph codes beyond the decimal digits
    localparam logic [3:0] DIGIT_OFF = 4'd10;
    localparam logic [3:0] DIGIT_P   = 4'd11;

endpackage

// File: rtl/bcd_step.sv
// rtl/bcd_step.sv - saturating 2-digit BCD increment/decrement
module bcd_step (
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       dir,
    output logic [3:0] next_tens,
    output logic [3:0] next_ones
);

    // dir=1 counts up, dir=0 counts down; 99 and 00 hold at the rails
    always_comb begin
        next_tens = tens;
        next_ones = ones;
        if (dir) begin
            if (ones != 4'd9) begin
                next_ones = ones + 4'd1;
            end else if (tens != 4'd9) begin
                next_ones = 4'd0;
                next_tens = tens + 4'd1;
            end
        end else begin
            if (ones != 4'd0) begin
                next_ones = ones - 4'd1;
            end else if (tens != 4'd0) begin
                next_ones = 4'd9;
                next_tens = tens - 4'd1;
            end
        end
    end

endmodule

// File: rtl/score_arbiter.sv
// rtl/score_arbiter.sv - button-driven BCD scores with round-robin shared update unit
module score_arbiter
    import scoreboard_pkg::*;
#(
    parameter logic [3:0] WIN_TENS = 4'd2,
    parameter logic [3:0] WIN_ONES = 4'd1
) (
    input  logic       clk_1khz,
    input  logic       rst_ni,
    input  logic       p1_inc_i,
    input  logic       p1_dec_i,
    input  logic       p2_inc_i,
    input  logic       p2_dec_i,
    input  logic       clear_i,
    output logic [3:0] p1_tens_o,
    output logic [3:0] p1_ones_o,
    output logic [3:0] p2_tens_o,
    output logic [3:0] p2_ones_o,
    output logic [1:0] winner_o,
    output logic       game_over_o
);

    logic [4:0]       btn;
    logic [4:0]       btn_prev;
    logic [4:0]       ev;
    logic [1:0]       ev_inc;
    logic [1:0]       ev_dec;
    logic             clear_ev;
    state_t           state;
    player_t          grant;
    player_t          last_grant;
    player_t          pick;
    logic             step_up;
    logic [1:0]       inc_pend;
    logic [1:0]       dec_pend;
    logic [1:0]       req;
    logic [1:0]       served;
    logic [1:0]       inc_pend_n;
    logic [1:0]       dec_pend_n;
    logic [1:0]       both;
    logic [1:0][3:0]  tens_q;
    logic [1:0][3:0]  ones_q;
    logic [3:0]       next_tens;
    logic [3:0]       next_ones;
    logic             win_hit;

    assign btn      = {clear_i, p2_dec_i, p2_inc_i, p1_dec_i, p1_inc_i};
    assign ev       = btn & ~btn_prev;
    assign ev_inc   = {ev[2], ev[0]};
    assign ev_dec   = {ev[3], ev[1]};
    assign clear_ev = ev[4];
    assign req      = inc_pend | dec_pend;
    assign win_hit  = (tens_q[grant] == WIN_TENS) && (ones_q[grant] == WIN_ONES);

    // Single shared arithmetic unit; operands follow the latched grant
    bcd_step u_step (
        .tens      (tens_q[grant]),
        .ones      (ones_q[grant]),
        .dir       (step_up),
        .next_tens (next_tens),
        .next_ones (next_ones)
    );

    // Round-robin: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        pick = PL_P1;
        if (req[0] && req[1]) begin
            pick = (last_grant == PL_P1) ? PL_P2 : PL_P1;
        end else if (req[1]) begin
            pick = PL_P2;
        end
    end

    // Next pending bits: service clears, presses set, an inc/dec pair cancels
    always_comb begin
        served = 2'b00;
        if (state == UPDATE) begin
            served = (grant == PL_P2) ? 2'b10 : 2'b01;
        end
        inc_pend_n = (inc_pend & ~served) | ev_inc;
        dec_pend_n = (dec_pend & ~served) | ev_dec;
        both       = inc_pend_n & dec_pend_n;
        inc_pend_n = inc_pend_n & ~both;
        dec_pend_n = dec_pend_n & ~both;
        if (state == GAME_OVER || (state == CHECK && win_hit)) begin
            inc_pend_n = 2'b00;
            dec_pend_n = 2'b00;
        end
    end

    // Previous button levels for rising-edge detection
    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_prev <= 5'd0;
        end else begin
            btn_prev <= btn;
        end
    end

    // Control FSM with score, pending and result registers; clear edge overrides all
    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            grant       <= PL_P1;
            last_grant  <= PL_P2;
            step_up     <= 1'b0;
            inc_pend    <= 2'b00;
            dec_pend    <= 2'b00;
            tens_q      <= '0;
            ones_q      <= '0;
            winner_o    <= WIN_NONE;
            game_over_o <= 1'b0;
        end else if (clear_ev) begin
            state       <= IDLE;
            last_grant  <= PL_P2;
            inc_pend    <= 2'b00;
            dec_pend    <= 2'b00;
            tens_q      <= '0;
            ones_q      <= '0;
            winner_o    <= WIN_NONE;
            game_over_o <= 1'b0;
        end else begin
            inc_pend <= inc_pend_n;
            dec_pend <= dec_pend_n;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant   <= pick;
                        step_up <= inc_pend[pick];
                        state   <= UPDATE;
                    end
                end
                UPDATE: begin
                    tens_q[grant] <= next_tens;
                    ones_q[grant] <= next_ones;
                    last_grant    <= grant;
                    state         <= CHECK;
                end
                CHECK: begin
                    if (win_hit) begin
                        winner_o    <= (grant == PL_P2) ? WIN_P2 : WIN_P1;
                        game_over_o <= 1'b1;
                        state       <= GAME_OVER;
                    end else begin
                        state <= IDLE;
                    end
                end
                GAME_OVER: state <= GAME_OVER;
                default:   state <= IDLE;
            endcase
        end
    end

    assign p1_tens_o = tens_q[0];
    assign p1_ones_o = ones_q[0];
    assign p2_tens_o = tens_q[1];
    assign p2_ones_o = ones_q[1];

endmodule

// File: tb/tb_score_arbiter.sv
// tb/tb_score_arbiter.sv - self-checking bench for score_arbiter
module tb_score_arbiter;

    localparam logic [4:0] B_P1I = 5'b00001;
    localparam logic [4:0] B_P1D = 5'b00010;
    localparam logic [4:0] B_P2I = 5'b00100;
    localparam logic [4:0] B_P2D = 5'b01000;
    localparam logic [4:0] B_CLR = 5'b10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  btn;
    logic [3:0]  p1t_a, p1o_a, p2t_a, p2o_a, p1t_b, p1o_b, p2t_b, p2o_b;
    logic [1:0]  win_a, win_b;
    logic        go_a, go_b;
    logic [18:0] out_a, out_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign out_a = {p1t_a, p1o_a, p2t_a, p2o_a, win_a, go_a};
    assign out_b = {p1t_b, p1o_b, p2t_b, p2o_b, win_b, go_b};

    score_arbiter #(.WIN_TENS(4'd2), .WIN_ONES(4'd1)) dut (
        .clk_1khz(clk), .rst_ni(rst_n),
        .p1_inc_i(btn[0]), .p1_dec_i(btn[1]), .p2_inc_i(btn[2]), .p2_dec_i(btn[3]),
        .clear_i(btn[4]),
        .p1_tens_o(p1t_a), .p1_ones_o(p1o_a), .p2_tens_o(p2t_a), .p2_ones_o(p2o_a),
        .winner_o(win_a), .game_over_o(go_a)
    );

    score_arbiter #(.WIN_TENS(4'd9), .WIN_ONES(4'd9)) dut99 (
        .clk_1khz(clk), .rst_ni(rst_n),
        .p1_inc_i(btn[0]), .p1_dec_i(btn[1]), .p2_inc_i(btn[2]), .p2_dec_i(btn[3]),
        .clear_i(btn[4]),
        .p1_tens_o(p1t_b), .p1_ones_o(p1o_b), .p2_tens_o(p2t_b), .p2_ones_o(p2o_b),
        .winner_o(win_b), .game_over_o(go_b)
    );

    // Reference model: integer scores, a phase counter and per-player request flags
    int         sc[2][2];
    bit         ip[2][2];
    bit         dp[2][2];
    int         ph[2];
    int         gr[2];
    bit         gup[2];
    int         lastg[2];
    int         wn[2];
    int         winv[2] = '{21, 99};
    bit [4:0]   prv;

    function automatic logic [18:0] pack(int p1, int p2, int w, bit go);
        logic [3:0] a, b, c, d;
        a = 4'(p1 / 10);
        b = 4'(p1 % 10);
        c = 4'(p2 / 10);
        d = 4'(p2 % 10);
        return {a, b, c, d, 2'(w), go};
    endfunction

    task automatic model_reset(input int m);
        for (int p = 0; p < 2; p++) begin
            sc[m][p] = 0;
            ip[m][p] = 1'b0;
            dp[m][p] = 1'b0;
        end
        ph[m]    = 0;
        gr[m]    = 0;
        gup[m]   = 1'b0;
        lastg[m] = 1;
        wn[m]    = 0;
    endtask

    task automatic model_step(input int m, input bit [4:0] ev);
        int served;
        int nv;
        bit r0, r1;
        if (ev[4]) begin
            model_reset(m);
            return;
        end
        served = -1;
        case (ph[m])
            0: begin
                r0 = ip[m][0] | dp[m][0];
                r1 = ip[m][1] | dp[m][1];
                if (r0 || r1) begin
                    gr[m]  = (r0 && r1) ? 1 - lastg[m] : (r1 ? 1 : 0);
                    gup[m] = ip[m][gr[m]];
                    ph[m]  = 1;
                end
            end
            1: begin
                nv = sc[m][gr[m]] + (gup[m] ? 1 : -1);
                if (nv > 99) nv = 99;
                if (nv < 0)  nv = 0;
                sc[m][gr[m]] = nv;
                lastg[m] = gr[m];
                served   = gr[m];
                ph[m]    = 2;
            end
            2: begin
                if (sc[m][gr[m]] == winv[m]) begin
                    wn[m] = gr[m] + 1;
                    ph[m] = 3;
                end else begin
                    ph[m] = 0;
                end
            end
            default: ;
        endcase
        for (int p = 0; p < 2; p++) begin
            bit evi, evd;
            evi = (p == 0) ? ev[0] : ev[2];
            evd = (p == 0) ? ev[1] : ev[3];
            if (served == p) begin
                ip[m][p] = 1'b0;
                dp[m][p] = 1'b0;
            end
            ip[m][p] = ip[m][p] | evi;
            dp[m][p] = dp[m][p] | evd;
            if ((ip[m][p] && dp[m][p]) || ph[m] == 3) begin
                ip[m][p] = 1'b0;
                dp[m][p] = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (p1t,p1o,p2t,p2o|win|go)", name, got, exp);
        end
    endtask

    task automatic check_models();
        check("model_win21", out_a, pack(sc[0][0], sc[0][1], wn[0], ph[0] == 3));
        check("model_win99", out_b, pack(sc[1][0], sc[1][1], wn[1], ph[1] == 3));
    endtask

    // Drive one cycle of buttons at the falling edge, advance models, check after the rising edge
    task automatic tick(input logic [4:0] b);
        bit [4:0] ev;
        btn = b;
        ev  = b & ~prv;
        prv = b;
        model_step(0, ev);
        model_step(1, ev);
        @(negedge clk);
        check_models();
    endtask

    task automatic press(input logic [4:0] b);
        tick(b);
        tick(5'd0);
        tick(5'd0);
        tick(5'd0);
    endtask

    typedef struct {
        logic [4:0] b;
        int         p1;
        int         p2;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [4:0] rb;

        // btn, expected P1 score, expected P2 score after that edge (WIN 21 instance)
        tbl.push_back('{B_P1I, 0, 0}); tbl.push_back('{B_P1I, 0, 0}); tbl.push_back('{B_P1I, 1, 0});
        tbl.push_back('{B_P1I, 1, 0}); tbl.push_back('{B_P1I, 1, 0}); tbl.push_back('{5'd0, 1, 0});
        tbl.push_back('{B_CLR, 0, 0}); tbl.push_back('{5'd0, 0, 0});
        tbl.push_back('{B_P1I | B_P2I, 0, 0}); tbl.push_back('{5'd0, 0, 0}); tbl.push_back('{5'd0, 1, 0});
        tbl.push_back('{5'd0, 1, 0}); tbl.push_back('{5'd0, 1, 0}); tbl.push_back('{5'd0, 1, 1});
        tbl.push_back('{5'd0, 1, 1});
        tbl.push_back('{B_P1I, 1, 1}); tbl.push_back('{5'd0, 1, 1}); tbl.push_back('{5'd0, 2, 1});
        tbl.push_back('{5'd0, 2, 1});
        tbl.push_back('{B_P1I | B_P2I, 2, 1}); tbl.push_back('{5'd0, 2, 1}); tbl.push_back('{5'd0, 2, 2});
        tbl.push_back('{5'd0, 2, 2}); tbl.push_back('{5'd0, 2, 2}); tbl.push_back('{5'd0, 3, 2});
        tbl.push_back('{5'd0, 3, 2});
        tbl.push_back('{B_P1I | B_P1D, 3, 2}); tbl.push_back('{5'd0, 3, 2}); tbl.push_back('{5'd0, 3, 2});
        tbl.push_back('{5'd0, 3, 2});
        tbl.push_back('{B_P2D, 3, 2}); tbl.push_back('{5'd0, 3, 2}); tbl.push_back('{5'd0, 3, 1});
        tbl.push_back('{5'd0, 3, 1});
        tbl.push_back('{B_CLR | B_P2I, 0, 0}); tbl.push_back('{5'd0, 0, 0}); tbl.push_back('{5'd0, 0, 0});
        tbl.push_back('{5'd0, 0, 0});
        tbl.push_back('{B_P1D, 0, 0}); tbl.push_back('{5'd0, 0, 0}); tbl.push_back('{5'd0, 0, 0});
        tbl.push_back('{5'd0, 0, 0});

        rst_n = 1'b0;
        btn   = 5'd0;
        prv   = 5'd0;
        model_reset(0);
        model_reset(1);
        repeat (2) @(negedge clk);
        check("reset_state", out_a, pack(0, 0, 0, 0));
        check_models();
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].b);
            check($sformatf("vec%0d", i), out_a, pack(tbl[i].p1, tbl[i].p2, 0, 0));
        end

        // P2 reaches the 21 win, game freezes until a clear
        press(B_CLR);
        for (int i = 0; i < 20; i++) press(B_P2I);
        check("p2_at_20", out_a, pack(0, 20, 0, 0));
        press(B_P2I);
        check("p2_wins", out_a, pack(0, 21, 2, 1));
        press(B_P1I);
        press(B_P2D);
        check("frozen", out_a, pack(0, 21, 2, 1));
        press(B_CLR);
        check("cleared", out_a, pack(0, 0, 0, 0));
        press(B_P1I);
        check("after_clear", out_a, pack(1, 0, 0, 0));

        // P1 climbs to 99 on the WIN 99 instance
        press(B_CLR);
        for (int i = 1; i <= 99; i++) begin
            press(B_P1I);
            if (i == 9)  check("b_09", out_b, pack(9, 0, 0, 0));
            if (i == 10) check("b_carry_10", out_b, pack(10, 0, 0, 0));
        end
        check("b_win99", out_b, pack(99, 0, 1, 1));
        check("a_win21_p1", out_a, pack(21, 0, 1, 1));
        press(B_P1I);
        check("b_stays99", out_b, pack(99, 0, 1, 1));

        // Asynchronous reset while the shared unit is in UPDATE
        press(B_CLR);
        press(B_P1I);
        check("pre_reset", out_a, pack(1, 0, 0, 0));
        tick(B_P2I);
        tick(5'd0);
        rst_n = 1'b0;
        btn   = 5'd0;
        prv   = 5'd0;
        #1;
        model_reset(0);
        model_reset(1);
        check("reset_mid_update_a", out_a, pack(0, 0, 0, 0));
        check("reset_mid_update_b", out_b, pack(0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // Random button activity against the model
        rb = 5'd0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) rb[k] = ~rb[k];
            end
            if ($urandom_range(0, 47) == 0) rb[4] = ~rb[4];
            tick(rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
